// File: rtl/sdram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_req_arbiter
//  Brief    : Arbitrates the camera write port against the HDR read port,
//             turns the winning request into a single-cycle command pulse for
//             the SDRAM command FSM and tracks it to completion via `busy`.
//             One burst is outstanding at a time.
//  Options  : SDRAM_ARB_AUTOPRE_EN - issue auto-precharge command codes.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_req_arbiter #(
    parameter int ADDR_W      = 22,
    parameter int MAX_STREAK  = 4,
    parameter int ACK_TIMEOUT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              busy,
    input  logic              wr_req,
    input  logic              wr_urgent,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ack,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_done,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] cmd_addr
);

    // Command codes; only the encoding differs between builds.
`ifdef SDRAM_ARB_AUTOPRE_EN
    localparam logic [3:0] C_CMD_WR = 4'b0100;
    localparam logic [3:0] C_CMD_RD = 4'b0011;
`else
    localparam logic [3:0] C_CMD_WR = 4'b0010;
    localparam logic [3:0] C_CMD_RD = 4'b0001;
`endif

    localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam int CNT_W    = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    localparam logic [STREAK_W-1:0] C_STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [STREAK_W-1:0] C_STREAK_ONE = STREAK_W'(1);
    localparam logic [CNT_W-1:0]    C_CNT_LOAD   = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0]    C_CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic                last_wr_q,   last_wr_d;   // 1: last grant went to write
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                reissue_q,   reissue_d;   // suppresses a second ack
    logic [3:0]          cmd_q,       cmd_d;
    logic [ADDR_W-1:0]   cmd_addr_q,  cmd_addr_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                wr_ack_q,    wr_ack_d;
    logic                rd_ack_q,    rd_ack_d;
    logic                wr_done_q,   wr_done_d;
    logic                rd_done_q,   rd_done_d;

    logic w_can_grant;
    logic w_pick_wr;

    // Arbitration decision: sole requester, then bounded urgent-write
    // priority, then round-robin against the previous grant.
    always_comb begin
        w_can_grant = init_done && !busy && (wr_req || rd_req);
        w_pick_wr   = 1'b0;
        if (wr_req && !rd_req) begin
            w_pick_wr = 1'b1;
        end else if (!wr_req && rd_req) begin
            w_pick_wr = 1'b0;
        end else if (wr_urgent && (streak_q < C_STREAK_MAX)) begin
            w_pick_wr = 1'b1;
        end else begin
            w_pick_wr = !last_wr_q;
        end
    end

    // Next-state and registered-output logic; pulses default low.
    always_comb begin
        state_d     = state_q;
        last_wr_d   = last_wr_q;
        streak_d    = streak_q;
        cnt_d       = cnt_q;
        reissue_d   = reissue_q;
        cmd_d       = cmd_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_valid_d = 1'b0;
        wr_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_can_grant) begin
                    state_d    = S_ISSUE;
                    last_wr_d  = w_pick_wr;
                    reissue_d  = 1'b0;
                    cmd_d      = w_pick_wr ? C_CMD_WR : C_CMD_RD;
                    cmd_addr_d = w_pick_wr ? wr_addr : rd_addr;
                    if (!w_pick_wr) begin
                        streak_d = '0;
                    end else if (wr_urgent && rd_req && (streak_q < C_STREAK_MAX)) begin
                        streak_d = streak_q + C_STREAK_ONE;
                    end
                end
            end
            S_ISSUE: begin
                cmd_valid_d = 1'b1;
                if (!reissue_q) begin
                    wr_ack_d = last_wr_q;
                    rd_ack_d = !last_wr_q;
                end
                cnt_d   = C_CNT_LOAD;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                    // The FSM never picked the command up: send it again.
                    if (cnt_q <= C_CNT_ONE) begin
                        state_d   = S_ISSUE;
                        reissue_d = 1'b1;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!busy) begin
                    wr_done_d = last_wr_q;
                    rd_done_d = !last_wr_q;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_wr_q   <= 1'b0;
            streak_q    <= '0;
            cnt_q       <= '0;
            reissue_q   <= 1'b0;
            cmd_q       <= '0;
            cmd_addr_q  <= '0;
            cmd_valid_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            streak_q    <= streak_d;
            cnt_q       <= cnt_d;
            reissue_q   <= reissue_d;
            cmd_q       <= cmd_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_valid_q <= cmd_valid_d;
            wr_ack_q    <= wr_ack_d;
            rd_ack_q    <= rd_ack_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_valid = cmd_valid_q;
    assign wr_ack    = wr_ack_q;
    assign rd_ack    = rd_ack_q;
    assign wr_done   = wr_done_q;
    assign rd_done   = rd_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_req_arbiter
//  Brief    : Directed self-checking bench for sdram_req_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_req_arbiter;

`ifdef SDRAM_ARB_AUTOPRE_EN
    localparam logic [3:0] C_WR = 4'b0100;
    localparam logic [3:0] C_RD = 4'b0011;
`else
    localparam logic [3:0] C_WR = 4'b0010;
    localparam logic [3:0] C_RD = 4'b0001;
`endif

    logic        clk = 1'b0;
    logic        rst_n, init_done, busy;
    logic        wr_req, wr_urgent, rd_req;
    logic [21:0] wr_addr, rd_addr;
    logic        wr_ack, wr_done, rd_ack, rd_done, cmd_valid;
    logic [3:0]  cmd;
    logic [21:0] cmd_addr;

    int checks = 0;
    int errors = 0;

    sdram_req_arbiter #(.ADDR_W(22), .MAX_STREAK(4), .ACK_TIMEOUT(3)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .busy(busy),
        .wr_req(wr_req), .wr_urgent(wr_urgent), .wr_addr(wr_addr),
        .wr_ack(wr_ack), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_done(rd_done),
        .cmd(cmd), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then stable and new inputs may be driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for a command, check grant/code/address, answer with a short busy
    // window and check the matching done pulse.
    task automatic serve_burst(input logic exp_wr, input logic [21:0] exp_addr, input string tag);
        int n;
        n = 0;
        while (cmd_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check({tag, " cmd_valid"}, {31'd0, cmd_valid}, 32'd1);
        check({tag, " acks"}, {30'd0, wr_ack, rd_ack}, exp_wr ? 32'd2 : 32'd1);
        check({tag, " cmd"}, {28'd0, cmd}, exp_wr ? {28'd0, C_WR} : {28'd0, C_RD});
        check({tag, " addr"}, {10'd0, cmd_addr}, {10'd0, exp_addr});
        step();
        busy = 1'b1;
        step();
        step();
        step();
        busy = 1'b0;
        n = 0;
        while (!(wr_done || rd_done) && n < 5) begin
            step();
            n++;
        end
        check({tag, " done"}, {30'd0, wr_done, rd_done}, exp_wr ? 32'd2 : 32'd1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int cnt_a, cnt_b, cnt_c;
        rst_n = 1'b0; init_done = 1'b0; busy = 1'b0;
        wr_req = 1'b0; wr_urgent = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0;

        // Reset state
        apply_reset();
        check("reset outputs", {cmd_addr, cmd, cmd_valid, wr_ack, rd_ack, wr_done, rd_done}, 32'd0);

        // Single write with hand-placed timing
        init_done = 1'b1;
        wr_req = 1'b1;
        wr_addr = 22'h01234;
        step();
        check("sw no early valid", {31'd0, cmd_valid}, 32'd0);
        step();
        check("sw cmd_valid c2", {31'd0, cmd_valid}, 32'd1);
        check("sw wr_ack", {30'd0, wr_ack, rd_ack}, 32'd2);
        check("sw cmd", {28'd0, cmd}, {28'd0, C_WR});
        check("sw addr", {10'd0, cmd_addr}, 32'h01234);
        wr_req = 1'b0;
        wr_addr = 22'h3FFFFF;
        step();
        check("sw valid one cycle", {30'd0, cmd_valid, wr_ack}, 32'd0);
        busy = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            cnt_a += int'(wr_done) + int'(rd_done) + int'(cmd_valid);
        end
        check("sw quiet while busy", cnt_a, 0);
        busy = 1'b0;
        step();
        check("sw wr_done", {30'd0, wr_done, rd_done}, 32'd2);
        step();
        check("sw done pulse", {30'd0, wr_done, rd_done}, 32'd0);

        // Tie round-robin from reset: W R W R
        apply_reset();
        wr_addr = 22'h00AAA;
        rd_addr = 22'h00555;
        wr_req = 1'b1;
        rd_req = 1'b1;
        serve_burst(1'b1, 22'h00AAA, "rr0");
        serve_burst(1'b0, 22'h00555, "rr1");
        serve_burst(1'b1, 22'h00AAA, "rr2");
        serve_burst(1'b0, 22'h00555, "rr3");

        // Urgent streak limit: 4 writes, 1 read, writes resume
        wr_urgent = 1'b1;
        serve_burst(1'b1, 22'h00AAA, "urg0");
        serve_burst(1'b1, 22'h00AAA, "urg1");
        serve_burst(1'b1, 22'h00AAA, "urg2");
        serve_burst(1'b1, 22'h00AAA, "urg3");
        serve_burst(1'b0, 22'h00555, "urg4");
        serve_burst(1'b1, 22'h00AAA, "urg5");

        // Dropped command: reissue after timeout, single ack
        wr_urgent = 1'b0;
        rd_req = 1'b0;
        wr_addr = 22'h2BEEF;
        cnt_a = 0;
        while (cmd_valid !== 1'b1 && cnt_a < 10) begin
            step();
            cnt_a++;
        end
        check("drop first valid", {30'd0, cmd_valid, wr_ack}, 32'd3);
        wr_req = 1'b0;
        wr_addr = 22'h00001;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            cnt_a += int'(cmd_valid);
            cnt_b += int'(wr_ack);
        end
        check("drop no early reissue", cnt_a, 0);
        step();
        cnt_b += int'(wr_ack) + int'(rd_ack);
        check("drop reissue valid", {31'd0, cmd_valid}, 32'd1);
        check("drop reissue cmd", {28'd0, cmd}, {28'd0, C_WR});
        check("drop reissue addr", {10'd0, cmd_addr}, 32'h2BEEF);
        check("drop single ack", cnt_b, 0);
        step();
        busy = 1'b1;
        step();
        step();
        busy = 1'b0;
        cnt_a = 0;
        while (!(wr_done || rd_done) && cnt_a < 5) begin
            step();
            cnt_a++;
        end
        check("drop done", {30'd0, wr_done, rd_done}, 32'd2);

        // Refresh busy in IDLE blocks the read grant
        busy = 1'b1;
        rd_req = 1'b1;
        rd_addr = 22'h15A5A;
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            cnt_a += int'(cmd_valid) + int'(wr_done) + int'(rd_done) + int'(rd_ack);
        end
        check("refresh blocked", cnt_a, 0);
        busy = 1'b0;
        step();
        check("refresh latch cycle", {31'd0, cmd_valid}, 32'd0);
        step();
        check("refresh read issued", {30'd0, cmd_valid, rd_ack}, 32'd3);
        check("refresh read cmd", {28'd0, cmd}, {28'd0, C_RD});
        check("refresh read addr", {10'd0, cmd_addr}, 32'h15A5A);
        rd_req = 1'b0;

        // Reset mid-burst in WAIT_DONE
        step();
        busy = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        step();
        check("midrst outputs", {cmd_addr, cmd, cmd_valid, wr_ack, rd_ack, wr_done, rd_done}, 32'd0);
        rst_n = 1'b1;
        busy = 1'b0;
        cnt_c = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            cnt_c += int'(rd_done) + int'(wr_done) + int'(cmd_valid);
        end
        check("midrst no done", cnt_c, 0);
        wr_addr = 22'h0C0DE;
        rd_addr = 22'h0D0D0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        serve_burst(1'b1, 22'h0C0DE, "midrst tie");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_req_arbiter.md
# sdram_req_arbiter

Upstream stage of the SDRAM command FSM. Arbitrates between the camera write port and the HDR read port, converts the winning request into a single-cycle command/address pulse for the command FSM, and tracks the command to completion through the FSM's `busy` flag. Only one SDRAM burst is outstanding at a time.

## Interface

Parameters:
- `ADDR_W`, 22: width of the SDRAM burst address (bank, row and column packed).
- `MAX_STREAK`, 4: maximum consecutive urgent write grants while a read is pending.
- `ACK_TIMEOUT`, 3: cycles to wait for `busy` to rise after issue before reissuing.

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- `clk` in 1: system clock, 133.33 MHz.
- `rst_n` in 1: synchronous active-low reset.
- `init_done` in 1: SDRAM initialisation complete.
- `busy` in 1: command FSM busy flag.
- `wr_req` in 1: write port request, level.
- `wr_urgent` in 1: write FIFO near full.
- `wr_addr` in ADDR_W: write burst address.
- `wr_ack` out 1: pulse, write command accepted.
- `wr_done` out 1: pulse, write burst complete.
- `rd_req` in 1: read port request, level.
- `rd_addr` in ADDR_W: read burst address.
- `rd_ack` out 1: pulse, read command accepted.
- `rd_done` out 1: pulse, read burst complete.
- `cmd` out 4: command code sent to the FSM.
- `cmd_valid` out 1: command strobe.
- `cmd_addr` out ADDR_W: address of the issued command.

## Operation

- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Stays in IDLE unless `init_done` = 1, `busy` = 0 and at least one request is high.
  - On exit, latches the grant, `cmd` and `cmd_addr`, then goes to ISSUE.
- Arbitration, in priority order:
  1. Only one request high: that port wins.
  2. Both high and `wr_urgent` = 1 and `streak` < MAX_STREAK: write wins.
  3. Otherwise, round-robin: the port not granted last time wins.
- `streak`:
  - Increments on each urgent-write grant made while `rd_req` = 1.
  - Clears on any read grant.
  - Saturates at MAX_STREAK.
- ISSUE:
  - `cmd_valid` = 1 for exactly one cycle.
  - The matching `wr_ack` / `rd_ack` pulses in the same cycle.
  - Loads the timeout counter with ACK_TIMEOUT, then goes to WAIT_BUSY.
- WAIT_BUSY:
  - If `busy` = 1, go to WAIT_DONE.
  - Else the counter decrements; when it reaches 0, return to ISSUE and reissue the identical command. No second ack is generated.
- WAIT_DONE:
  - When `busy` = 0, pulse `wr_done` or `rd_done` for one cycle and return to IDLE.
- Command codes: write = 4'b0010, read = 4'b0001. With AUTOPRE, write = 4'b0100 and read = 4'b0011.
- Requesters hold `*_req` and `*_addr` stable until their ack. The address is latched in IDLE, so changes after the grant are ignored.
- `init_done` deasserting mid-operation: the current state machine continues. No new grants are made until `init_done` returns.
- Busy caused by auto-refresh or an LMR, outside any of this block's commands:
  - Blocks grants in IDLE.
  - Is never mistaken for completion, because WAIT_DONE is entered only after an issue.

## Timing

- Reset values: all outputs 0, state IDLE, last-grant = read (so the first tie goes to write), `streak` = 0.
- All outputs are registered.
- Request to `cmd_valid`: 2 cycles (IDLE latch, then ISSUE). The ack is coincident with `cmd_valid`.
- `done` follows the first cycle in which `busy` = 0 in WAIT_DONE by one cycle.
- Minimum request-to-request spacing: the next grant occurs no earlier than 1 cycle after `done`.
- A request deasserted after the grant but before ISSUE is still issued; there is no cancel.
- Reset mid-operation (any state): returns to IDLE next cycle, outputs clear, and no done pulse is generated.

## Configuration

- `SDRAM_ARB_AUTOPRE_EN` defined: auto-precharge codes are issued (read 4'b0011, write 4'b0100). Each burst closes its row.
- Undefined: plain codes are issued (read 4'b0001, write 4'b0010).
- Arbitration and timing are identical in both builds.

## Test plan

- **Single write:** reset, `init_done` = 1, `wr_req` = 1, `wr_addr` = 22'h01234, `busy` rising 1 cycle after `cmd_valid` and falling 12 cycles later.
  - Required: `cmd_valid` on cycle 2 with `cmd` = 4'b0010 (4'b0100 with the macro) and `cmd_addr` = 22'h01234; `wr_ack` coincident with `cmd_valid`; one `wr_done` pulse.
- **Tie round-robin:** `wr_req` and `rd_req` both held, `wr_urgent` = 0, 4 commands.
  - Required: grant order W, R, W, R.
- **Urgent streak limit:** both requests held, `wr_urgent` = 1, MAX_STREAK = 4.
  - Required: 4 writes, then 1 read, then writes resume.
- **Dropped command:** `busy` held 0 for 3 cycles after `cmd_valid`.
  - Required: second `cmd_valid` with the same code and address; exactly one `wr_ack`.
- **Refresh busy:** `busy` = 1 for 10 cycles while `rd_req` = 1 in IDLE.
  - Required: no `cmd_valid` until 1 cycle after `busy` falls; no spurious done.
- **Reset mid-burst:** `rst_n` = 0 during WAIT_DONE.
  - Required: all outputs 0 next cycle; no `rd_done`; first tie after reset grants write.
